syn_current_driver: RTL and testbench

//  Receive end of the neuron spike interface: turns presynaptic spike vectors into the

---
 rtl/syn_drv_pkg.sv | 33 +++
 rtl/syn_current_driver_weight_rf.sv | 31 +++
 rtl/syn_current_driver.sv | 109 ++++++++++
 tb/tb_syn_current_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_drv_pkg.sv
// Shared types and arithmetic helpers for the synaptic current driver.
// Helpers work on int so they serve any current width up to 31 bits.
package syn_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DECAY = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed add clamped to the range of a width-bit two's complement value.
    function automatic int sat_add(input int a, input int b, input int width);
        int hi;
        int lo;
        int sum;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        sum = a + b;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

    // One leak step; small positive values step down by one so the current reaches exactly zero.
    function automatic int leak(input int acc, input int shift);
        int d;
        d = acc >>> shift;
        if (d == 0 && acc > 0) return acc - 1;
        return acc - d;
    endfunction

endpackage

// File: rtl/syn_current_driver_weight_rf.sv
// N_IN x W_W synaptic weight register file: one synchronous write port, one
// combinational read port, all entries cleared by reset.
module syn_weight_rf
    import syn_drv_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int W_W  = 8,
    parameter int A_W  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  logic [W_W-1:0] wdata,
    input  logic [A_W-1:0] raddr,
    output logic [W_W-1:0] rdata
);

    logic [W_W-1:0] mem [N_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++) mem[k] <= '0;
        end else if (we && (int'(waddr) < N_IN)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_current_driver.sv
// Leaky synaptic current integrator fed by presynaptic spike vectors; i_syn is Q8.8 nA.
// Build option SYN_SPIKE_LATCH_EN: spikes between ticks are held until the next tick.
module syn_current_driver
    import syn_drv_pkg::*;
#(
    parameter int N_IN      = 8,
    parameter int W_W       = 8,
    parameter int I_W       = 16,
    parameter int TAU_SHIFT = 4,
    localparam int A_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [N_IN-1:0]       spike_in,
    input  logic                  w_we,
    input  logic [A_W-1:0]        w_addr,
    input  logic [W_W-1:0]        w_data,
    output logic                  w_ready,
    output logic signed [I_W-1:0] i_syn,
    output logic                  i_valid,
    output logic                  busy,
    output logic                  overrun,
    output state_t                fsm_state
);

    state_t                state;
    logic signed [I_W-1:0] acc;
    logic signed [I_W-1:0] acc_add;
    logic [N_IN-1:0]       snap;
    logic [N_IN-1:0]       spikes_now;
    logic [A_W-1:0]        idx;
    logic signed [W_W-1:0] w_rd;

    assign fsm_state = state;
    assign w_ready   = (state == IDLE);
    assign busy      = (state != IDLE);
    assign overrun   = tick && busy;

    syn_weight_rf #(.N_IN(N_IN), .W_W(W_W), .A_W(A_W)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we && w_ready),
        .waddr (w_addr),
        .wdata (w_data),
        .raddr (idx),
        .rdata (w_rd)
    );

`ifdef SYN_SPIKE_LATCH_EN
    logic [N_IN-1:0] pending;

    // The snapshot consumes everything seen so far, including this cycle's spikes.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else if (tick && w_ready) pending <= '0;
        else pending <= pending | spike_in;
    end

    assign spikes_now = pending | spike_in;
`else
    assign spikes_now = spike_in;
`endif

    always_comb begin
        acc_add = acc;
        if (snap[idx]) acc_add = I_W'(sat_add(int'(acc), int'(w_rd), I_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            i_syn   <= '0;
            i_valid <= 1'b0;
            snap    <= '0;
            idx     <= '0;
        end else begin
            i_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap  <= spikes_now;
                        idx   <= '0;
                        state <= DECAY;
                    end
                end
                DECAY: begin
                    acc   <= I_W'(leak(int'(acc), TAU_SHIFT));
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc_add;
                    // Publish on the last add so i_syn and i_valid appear together in DONE.
                    if (idx == A_W'(N_IN - 1)) begin
                        i_syn   <= acc_add;
                        i_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + A_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_current_driver.sv
// Scoreboard bench for syn_current_driver: directed ticks push expected currents,
// a negedge monitor pops them on every i_valid and also checks output latency.
module tb_syn_current_driver;
    import syn_drv_pkg::*;

    localparam int N_IN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        tick_w = 1'b0;
    logic [7:0]  spike_in = '0;
    logic        w_we = 1'b0;
    logic        w_we_w = 1'b0;
    logic [2:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic [11:0] w_data_w = '0;

    logic               w_ready, i_valid, busy, overrun;
    logic signed [15:0] i_syn;
    state_t             fsm_state;
    logic               w_ready_w, i_valid_w, busy_w, overrun_w;
    logic signed [15:0] i_syn_w;
    state_t             fsm_state_w;

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    logic [15:0] wexp_q[$];
    int          wcyc_q[$];
    logic [15:0] e_m, e_w;
    int          c_m, c_w;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    syn_current_driver dut (
        .clk(clk), .rst(rst), .tick(tick), .spike_in(spike_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .w_ready(w_ready), .i_syn(i_syn), .i_valid(i_valid),
        .busy(busy), .overrun(overrun), .fsm_state(fsm_state)
    );

    // Wider weights so that saturation of the 16-bit current is reachable.
    syn_current_driver #(.W_W(12)) dut_wide (
        .clk(clk), .rst(rst), .tick(tick_w), .spike_in(spike_in),
        .w_we(w_we_w), .w_addr(w_addr), .w_data(w_data_w),
        .w_ready(w_ready_w), .i_syn(i_syn_w), .i_valid(i_valid_w),
        .busy(busy_w), .overrun(overrun_w), .fsm_state(fsm_state_w)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (i_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_i_valid", 1, 0);
            end else begin
                e_m = exp_q.pop_front();
                c_m = cyc_q.pop_front();
                check("i_syn", int'($signed(i_syn)), int'($signed(e_m)));
                check("latency", cyc, c_m);
            end
        end
        if (i_valid_w) begin
            if (wexp_q.size() == 0) begin
                check("unexpected_i_valid_wide", 1, 0);
            end else begin
                e_w = wexp_q.pop_front();
                c_w = wcyc_q.pop_front();
                check("i_syn_wide", int'($signed(i_syn_w)), int'($signed(e_w)));
                check("latency_wide", cyc, c_w);
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_w(input bit wide, input int addr, input int val);
        @(negedge clk);
        w_addr = 3'(addr);
        if (wide) begin
            w_we_w = 1'b1;
            w_data_w = 12'(val);
        end else begin
            w_we = 1'b1;
            w_data = 8'(val);
        end
        @(negedge clk);
        w_we = 1'b0;
        w_we_w = 1'b0;
    endtask

    task automatic run_tick(input bit wide, input logic [7:0] spikes, input int exp_val);
        @(negedge clk);
        spike_in = spikes;
        if (wide) begin
            tick_w = 1'b1;
            wexp_q.push_back(16'(exp_val));
            wcyc_q.push_back(cyc + N_IN + 2);
            #1 check("overrun_idle_wide", int'(overrun_w), 0);
        end else begin
            tick = 1'b1;
            exp_q.push_back(16'(exp_val));
            cyc_q.push_back(cyc + N_IN + 2);
            #1 check("overrun_idle", int'(overrun), 0);
        end
        @(negedge clk);
        tick = 1'b0;
        tick_w = 1'b0;
        spike_in = '0;
        repeat (N_IN + 3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and empty tick
        do_reset();
        check("rst_i_syn", int'(i_syn), 0);
        check("rst_i_valid", int'(i_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_w_ready", int'(w_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(fsm_state), int'(IDLE));
        run_tick(0, 8'h00, 0);

        // Single weight, then leak
        write_w(0, 3, 40);
        run_tick(0, 8'h08, 40);
        run_tick(0, 8'h00, 38);
        run_tick(0, 8'h00, 36);

        // Leak converges to exactly zero from +1 and from -1
        do_reset();
        write_w(0, 0, 1);
        run_tick(0, 8'h01, 1);
        run_tick(0, 8'h00, 0);
        write_w(0, 0, -1);
        run_tick(0, 8'h01, -1);
        run_tick(0, 8'h00, 0);

        // All inputs at full-scale weights, sign crossing without wrap
        do_reset();
        for (int k = 0; k < N_IN; k++) write_w(0, k, 127);
        run_tick(0, 8'hFF, 1016);
        run_tick(0, 8'hFF, 1969);
        for (int k = 0; k < N_IN; k++) write_w(0, k, -128);
        run_tick(0, 8'hFF, 822);
        run_tick(0, 8'hFF, -253);

        // Saturation at both rails on the wide-weight instance
        do_reset();
        for (int k = 0; k < N_IN; k++) write_w(1, k, 2047);
        run_tick(1, 8'hFF, 16376);
        run_tick(1, 8'hFF, 31729);
        run_tick(1, 8'hFF, 32767);
        run_tick(1, 8'hFF, 32767);
        do_reset();
        for (int k = 0; k < N_IN; k++) write_w(1, k, -2048);
        run_tick(1, 8'hFF, -16384);
        run_tick(1, 8'hFF, -31744);
        run_tick(1, 8'hFF, -32768);
        run_tick(1, 8'hFF, -32768);

        // Tick while busy is dropped; write while busy is ignored
        do_reset();
        write_w(0, 3, 40);
        @(negedge clk);
        spike_in = 8'h08;
        tick = 1'b1;
        exp_q.push_back(16'd40);
        cyc_q.push_back(cyc + N_IN + 2);
        @(negedge clk);
        tick = 1'b0;
        spike_in = '0;
        @(negedge clk);
        tick = 1'b1;
        #1;
        check("overrun_busy", int'(overrun), 1);
        check("w_ready_busy", int'(w_ready), 0);
        @(negedge clk);
        tick = 1'b0;
        w_we = 1'b1;
        w_addr = 3'd3;
        w_data = 8'd100;
        @(negedge clk);
        w_we = 1'b0;
        repeat (N_IN + 2) @(negedge clk);
        run_tick(0, 8'h08, 78);

        // Write and tick in the same idle cycle: scan sees the new weight
        do_reset();
        @(negedge clk);
        w_we = 1'b1;
        w_addr = 3'd0;
        w_data = 8'd25;
        tick = 1'b1;
        spike_in = 8'h01;
        exp_q.push_back(16'd25);
        cyc_q.push_back(cyc + N_IN + 2);
        @(negedge clk);
        w_we = 1'b0;
        tick = 1'b0;
        spike_in = '0;
        repeat (N_IN + 3) @(negedge clk);

        // Spike between ticks: held only with the latch option
        do_reset();
        write_w(0, 0, 10);
        run_tick(0, 8'h01, 10);
        @(negedge clk);
        spike_in = 8'h01;
        @(negedge clk);
        spike_in = '0;
`ifdef SYN_SPIKE_LATCH_EN
        run_tick(0, 8'h00, 19);
`else
        run_tick(0, 8'h00, 9);
`endif

        // Reset during ACCUM aborts the scan with no i_valid
        @(negedge clk);
        tick = 1'b1;
        spike_in = 8'h01;
        @(negedge clk);
        tick = 1'b0;
        spike_in = '0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_i_syn", int'(i_syn), 0);
        check("abort_busy", int'(busy), 0);
        repeat (N_IN + 4) @(negedge clk);
        check("abort_idle_state", int'(fsm_state), int'(IDLE));

        // Final report
        check("scoreboard_drained", exp_q.size() + wexp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
